// File: rtl/sram_fetch_unit.sv
// sram_fetch_unit: PC-driven instruction fetch from a 1-cycle-latency SRAM into a 2-entry FIFO,
// with branch redirect and halt-opcode stop.
module sram_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  output logic [ADDR_WIDTH-1:0] sramAddress,
  output logic [DATA_WIDTH-1:0] sramInputData,
  output logic                  sramWriteEnable,
  input  logic [DATA_WIDTH-1:0] sramOutputData,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirectAddr,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instrAddr,
  input  logic                  instrReady,
  output logic                  halted
);
  typedef enum logic {FETCH, HALT} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, last_addr_q, last_addr_d, infl_addr_q, infl_addr_d;
  logic                  infl_q, infl_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d, occ;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [ADDR_WIDTH-1:0] addr_d [2];
  logic                  pop, push, issue, wr_ptr;

  assign sramInputData   = '0;
  assign sramWriteEnable = 1'b0;
  assign instrValid      = count_q != 2'd0;
  assign instr           = instrValid ? data_q[rd_ptr_q] : '0;
  assign instrAddr       = instrValid ? addr_q[rd_ptr_q] : '0;
  assign halted          = state_q == HALT && count_q == 2'd0 && !infl_q;
  assign pop             = instrValid && instrReady;
  // Slots already committed (buffered + in flight); a pop this cycle frees one for the new issue.
  assign occ             = count_q + {1'b0, infl_q};
  assign issue           = state_q == FETCH && !redirect && (occ < 2'd2 || (occ == 2'd2 && pop));
  assign push            = infl_q && state_q == FETCH && !redirect;
  assign wr_ptr          = rd_ptr_q ^ count_q[0];
  assign sramAddress     = issue ? pc_q : last_addr_q;

  always_comb begin
    pc_d        = redirect ? redirectAddr : issue ? pc_q + 1'b1 : pc_q;
    last_addr_d = issue ? pc_q : last_addr_q;
    infl_d      = issue;
    infl_addr_d = issue ? pc_q : infl_addr_q;
    count_d     = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d    = rd_ptr_q ^ pop;
    data_d      = data_q;
    addr_d      = addr_q;
    if (push) begin
      data_d[wr_ptr] = sramOutputData;
      addr_d[wr_ptr] = infl_addr_q;
    end
    state_d     = redirect ? FETCH
                : (push && sramOutputData[DATA_WIDTH-1 -: 6] == HALT_OPCODE) ? HALT : state_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      last_addr_q <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= 1'b0;
      data_q      <= '{default: '0};
      addr_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      last_addr_q <= last_addr_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
    end
  end
endmodule

// File: tb/tb_sram_fetch_unit.sv
// tb_sram_fetch_unit: directed per-cycle vectors against sram_fetch_unit with a 1-cycle SRAM model.
module tb_sram_fetch_unit;
  logic        Clk, Reset_n, sramWriteEnable, redirect, instrValid, instrReady, halted;
  logic [15:0] sramAddress, redirectAddr, instrAddr;
  logic [31:0] sramInputData, sramOutputData, instr;
  logic [31:0] mem [0:65535];
  int          tests = 0, fails = 0;

  typedef struct packed {
    logic        rdy;
    logic        redir;
    logic [15:0] raddr;
    logic        ev;
    logic [31:0] ei;
    logic [15:0] ea;
    logic [15:0] es;
    logic        eh;
  } vec_t;

  vec_t tbl[$];

  sram_fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .sramAddress(sramAddress), .sramInputData(sramInputData),
    .sramWriteEnable(sramWriteEnable), .sramOutputData(sramOutputData), .redirect(redirect),
    .redirectAddr(redirectAddr), .instrValid(instrValid), .instr(instr), .instrAddr(instrAddr),
    .instrReady(instrReady), .halted(halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) sramOutputData <= mem[sramAddress];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t V(logic rdy, logic redir, logic [15:0] raddr, logic ev,
                             logic [31:0] ei, logic [15:0] ea, logic [15:0] es, logic eh);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.raddr = raddr; v.ev = ev;
    v.ei = ei; v.ea = ea; v.es = es; v.eh = eh;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    instrReady = v.rdy; redirect = v.redir; redirectAddr = v.raddr;
    @(negedge Clk);
    check({tag, " valid"}, 32'(instrValid), 32'(v.ev));
    if (v.ev) begin
      check({tag, " instr"}, instr, v.ei);
      check({tag, " instrAddr"}, 32'(instrAddr), 32'(v.ea));
    end
    check({tag, " sramAddress"}, 32'(sramAddress), 32'(v.es));
    check({tag, " halted"}, 32'(halted), 32'(v.eh));
    check({tag, " we/wdata"}, {31'(sramInputData != 0), sramWriteEnable}, 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0100_0000 | 32'(i);
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    mem[16'h0010] = 32'hAAAA0000;
    Reset_n = 1'b0; instrReady = 1'b1; redirect = 1'b0; redirectAddr = '0;
    // Stream, 5-cycle stall, resume, then redirect to 0x0010 mid-stream.
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 16'h0001, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h11111111, 16'h0000, 16'h0002, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h22222222, 16'h0001, 16'h0003, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h33333333, 16'h0002, 16'h0004, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(V(0, 0, 0, 1, 32'h44444444, 16'h0003, 16'h0004, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h44444444, 16'h0003, 16'h0005, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h01000004, 16'h0004, 16'h0006, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h01000005, 16'h0005, 16'h0007, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h01000006, 16'h0006, 16'h0008, 0));
    tbl.push_back(V(1, 1, 16'h0010, 1, 32'h01000007, 16'h0007, 16'h0008, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 16'h0010, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 16'h0011, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'hAAAA0000, 16'h0010, 16'h0012, 0));
    tbl.push_back(V(1, 0, 0, 1, 32'h01000011, 16'h0011, 16'h0013, 0));
    repeat (2) @(posedge Clk);
    #1;
    check("reset valid", 32'(instrValid), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset sramAddress", 32'(sramAddress), 32'd0);
    check("reset instr", instr, 32'd0);
    check("reset instrAddr", 32'(instrAddr), 32'd0);
    Reset_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("stream%0d", i));
    // Halt word at address 3: address 4 is issued but never delivered.
    mem[3] = 32'hFC000000;
    apply(V(1, 1, 16'h0000, 1, 32'h01000012, 16'h0012, 16'h0013, 0), "halt0");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0000, 0), "halt1");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0001, 0), "halt2");
    apply(V(1, 0, 0, 1, 32'h11111111, 16'h0000, 16'h0002, 0), "halt3");
    apply(V(1, 0, 0, 1, 32'h22222222, 16'h0001, 16'h0003, 0), "halt4");
    apply(V(1, 0, 0, 1, 32'h33333333, 16'h0002, 16'h0004, 0), "halt5");
    apply(V(1, 0, 0, 1, 32'hFC000000, 16'h0003, 16'h0004, 0), "halt6");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0004, 1), "halt7");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0004, 1), "halt8");
    apply(V(1, 1, 16'h0000, 0, 0, 0, 16'h0004, 1), "halt9");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0000, 0), "halt10");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0001, 0), "halt11");
    apply(V(1, 0, 0, 1, 32'h11111111, 16'h0000, 16'h0002, 0), "halt12");
    // Address wrap 0xFFFF -> 0x0000.
    apply(V(1, 1, 16'hFFFF, 1, 32'h22222222, 16'h0001, 16'h0002, 0), "wrap0");
    apply(V(1, 0, 0, 0, 0, 0, 16'hFFFF, 0), "wrap1");
    apply(V(1, 0, 0, 0, 0, 0, 16'h0000, 0), "wrap2");
    apply(V(1, 0, 0, 1, 32'h0100FFFF, 16'hFFFF, 16'h0001, 0), "wrap3");
    apply(V(1, 0, 0, 1, 32'h11111111, 16'h0000, 16'h0002, 0), "wrap4");
    // Short async reset pulse mid-stream.
    #2 Reset_n = 1'b0;
    #1;
    check("midrst valid", 32'(instrValid), 32'd0);
    check("midrst halted", 32'(halted), 32'd0);
    check("midrst sramAddress", 32'(sramAddress), 32'd0);
    check("midrst instr", instr, 32'd0);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #1;
    apply(V(1, 0, 0, 0, 0, 0, 16'h0001, 0), "midrst1");
    apply(V(1, 0, 0, 1, 32'h11111111, 16'h0000, 16'h0002, 0), "midrst2");
    apply(V(1, 0, 0, 1, 32'h22222222, 16'h0001, 16'h0003, 0), "midrst3");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
